// File: rtl/mac_operand_feeder.sv
// Streaming operand source for the MAC: buffers one vector and one matrix,
// replays them as J framed beats on start, then waits for the MAC's result.
module mac_operand_feeder #(
    parameter  int J       = 14,
    parameter  int A       = 2,
    parameter  int GAP     = 0,
    parameter  int TIMEOUT = 64,
    localparam int J_WIDTH = $clog2(J) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 v_wr_en,
    input  logic [J_WIDTH-1:0]   v_wr_addr,
    input  logic [63:0]          v_wr_data,
    input  logic                 m_wr_en,
    input  logic [J_WIDTH-1:0]   m_wr_addr,
    input  logic [A*64-1:0]      m_wr_data,
    input  logic                 start,
    input  logic                 beta_tvalid,
    output logic [63:0]          vinput,
    output logic                 vinput_tvalid,
    output logic                 vinput_tlast,
    output logic [A*64-1:0]      M_row,
    output logic                 M_row_tvalid,
    output logic                 M_row_tlast,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int AW = (J > 1) ? $clog2(J) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [J_WIDTH-1:0] LAST_K   = J_WIDTH'(J - 1);
    localparam logic [J_WIDTH-1:0] NUM_J    = J_WIDTH'(J);
    localparam logic [3:0]         GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT - 1);

    logic [63:0]        v_buf [J];
    logic [A*64-1:0]    m_buf [J];

    logic [1:0]         state;
    logic [J_WIDTH-1:0] k;
    logic [J_WIDTH-1:0] nk;
    logic [3:0]         gap_cnt;
    logic [TW-1:0]      to_cnt;
    logic               v_wr_ok;
    logic               m_wr_ok;

    assign nk      = k + J_WIDTH'(1);
    assign v_wr_ok = v_wr_en && (state == S_IDLE) && (v_wr_addr < NUM_J);
    assign m_wr_ok = m_wr_en && (state == S_IDLE) && (m_wr_addr < NUM_J);

    assign M_row_tvalid = vinput_tvalid;
    assign M_row_tlast  = vinput_tlast;

    // Buffers deliberately have no reset so their contents survive a frame abort.
    always_ff @(posedge clk) begin
        if (v_wr_ok)
            v_buf[v_wr_addr[AW-1:0]] <= v_wr_data;
        if (m_wr_ok)
            m_buf[m_wr_addr[AW-1:0]] <= m_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            k             <= '0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
            vinput        <= '0;
            M_row         <= '0;
            vinput_tvalid <= 1'b0;
            vinput_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= (v_wr_en && !v_wr_ok) || (m_wr_en && !m_wr_ok) ||
                    (start && (state != S_IDLE));
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_ISSUE;
                        busy          <= 1'b1;
                        k             <= '0;
                        vinput        <= v_buf[0];
                        M_row         <= m_buf[0];
                        vinput_tvalid <= 1'b1;
                        vinput_tlast  <= (J == 1);
                    end
                end
                S_ISSUE: begin
                    vinput_tvalid <= 1'b0;
                    vinput_tlast  <= 1'b0;
                    if (k == LAST_K) begin
                        state  <= S_WAIT;
                        to_cnt <= '0;
                    end else if (GAP == 0) begin
                        k             <= nk;
                        vinput        <= v_buf[nk[AW-1:0]];
                        M_row         <= m_buf[nk[AW-1:0]];
                        vinput_tvalid <= 1'b1;
                        vinput_tlast  <= (nk == LAST_K);
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state         <= S_ISSUE;
                        k             <= nk;
                        vinput        <= v_buf[nk[AW-1:0]];
                        M_row         <= m_buf[nk[AW-1:0]];
                        vinput_tvalid <= 1'b1;
                        vinput_tlast  <= (nk == LAST_K);
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    // A result arriving in the final timeout cycle still counts as success.
                    if (beta_tvalid) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: a short J=2 instance and a J=14
// instance with inter-beat gaps and a short result timeout.
module tb_mac_operand_feeder;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instance A: J=2, GAP=0, TIMEOUT=64
    logic         a_v_wr_en, a_m_wr_en, a_start, a_beta;
    logic [1:0]   a_v_wr_addr, a_m_wr_addr;
    logic [63:0]  a_v_wr_data, a_vinput;
    logic [127:0] a_m_wr_data, a_mrow;
    logic         a_vvalid, a_vlast, a_mvalid, a_mlast, a_busy, a_done, a_err;

    // Instance B: J=14, GAP=3, TIMEOUT=8
    logic         b_v_wr_en, b_m_wr_en, b_start, b_beta;
    logic [4:0]   b_v_wr_addr, b_m_wr_addr;
    logic [63:0]  b_v_wr_data, b_vinput;
    logic [127:0] b_m_wr_data, b_mrow;
    logic         b_vvalid, b_vlast, b_mvalid, b_mlast, b_busy, b_done, b_err;

    mac_operand_feeder #(.J(2), .A(2), .GAP(0), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst),
        .v_wr_en(a_v_wr_en), .v_wr_addr(a_v_wr_addr), .v_wr_data(a_v_wr_data),
        .m_wr_en(a_m_wr_en), .m_wr_addr(a_m_wr_addr), .m_wr_data(a_m_wr_data),
        .start(a_start), .beta_tvalid(a_beta),
        .vinput(a_vinput), .vinput_tvalid(a_vvalid), .vinput_tlast(a_vlast),
        .M_row(a_mrow), .M_row_tvalid(a_mvalid), .M_row_tlast(a_mlast),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    mac_operand_feeder #(.J(14), .A(2), .GAP(3), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .v_wr_en(b_v_wr_en), .v_wr_addr(b_v_wr_addr), .v_wr_data(b_v_wr_data),
        .m_wr_en(b_m_wr_en), .m_wr_addr(b_m_wr_addr), .m_wr_data(b_m_wr_data),
        .start(b_start), .beta_tvalid(b_beta),
        .vinput(b_vinput), .vinput_tvalid(b_vvalid), .vinput_tlast(b_vlast),
        .M_row(b_mrow), .M_row_tvalid(b_mvalid), .M_row_tlast(b_mlast),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    localparam logic [63:0]  D1 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0]  D2 = 64'h4000_0000_0000_0000;
    localparam logic [63:0]  D3 = 64'h4008_0000_0000_0000;
    localparam logic [63:0]  D4 = 64'h4010_0000_0000_0000;
    localparam logic [127:0] A_ROW0 = {D3, D2};
    localparam logic [127:0] A_ROW1 = {D4, D3};

    function automatic logic [63:0] exp_v(int i);
        return 64'hC000_0000_0000_0000 | 64'(i * 17 + 5);
    endfunction

    function automatic logic [127:0] exp_m(int i);
        return {64'hAAAA_0000_0000_0000 | 64'(i), 64'h5555_0000_0000_0000 | 64'(i * 3 + 1)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {a_v_wr_en, a_m_wr_en, a_start, a_beta} = '0;
        {b_v_wr_en, b_m_wr_en, b_start, b_beta} = '0;
        a_v_wr_addr = '0; a_m_wr_addr = '0; a_v_wr_data = '0; a_m_wr_data = '0;
        b_v_wr_addr = '0; b_m_wr_addr = '0; b_v_wr_data = '0; b_m_wr_data = '0;
        tick; tick;
        n_cmp++; if ({a_vvalid, a_vlast, a_mvalid, a_mlast, a_busy, a_done, a_err} !== 7'b0) begin
            n_err++; $display("[TB] FAIL reset_a_ctrl: got %b want 0000000", {a_vvalid, a_vlast, a_mvalid, a_mlast, a_busy, a_done, a_err}); end
        n_cmp++; if ({a_vinput, a_mrow} !== 192'b0) begin
            n_err++; $display("[TB] FAIL reset_a_data: got %h %h want 0", a_vinput, a_mrow); end
        n_cmp++; if ({b_vvalid, b_vlast, b_busy, b_done, b_err} !== 5'b0 || b_vinput !== 64'b0) begin
            n_err++; $display("[TB] FAIL reset_b: got ctrl %b data %h want 0", {b_vvalid, b_vlast, b_busy, b_done, b_err}, b_vinput); end
        rst = 1'b0;
        tick;
    endtask

    task automatic load_buffers;
        a_v_wr_en = 1'b1; a_m_wr_en = 1'b1;
        a_v_wr_addr = 2'd0; a_v_wr_data = D1; a_m_wr_addr = 2'd0; a_m_wr_data = A_ROW0;
        tick;
        a_v_wr_addr = 2'd1; a_v_wr_data = D2; a_m_wr_addr = 2'd1; a_m_wr_data = A_ROW1;
        tick;
        a_v_wr_en = 1'b0; a_m_wr_en = 1'b0;
        b_v_wr_en = 1'b1; b_m_wr_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            b_v_wr_addr = 5'(i); b_v_wr_data = exp_v(i);
            b_m_wr_addr = 5'(i); b_m_wr_data = exp_m(i);
            tick;
            n_cmp++; if (b_err !== 1'b0) begin
                n_err++; $display("[TB] FAIL load_b_err idx %0d: got %b want 0", i, b_err); end
        end
        b_v_wr_en = 1'b0; b_m_wr_en = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        n_cmp++; if ({a_vvalid, a_vlast, a_mvalid, a_mlast, a_busy} !== 5'b10101) begin
            n_err++; $display("[TB] FAIL basic_beat0_ctrl: got %b want 10101", {a_vvalid, a_vlast, a_mvalid, a_mlast, a_busy}); end
        n_cmp++; if (a_vinput !== D1 || a_mrow !== A_ROW0) begin
            n_err++; $display("[TB] FAIL basic_beat0_data: got %h %h want %h %h", a_vinput, a_mrow, D1, A_ROW0); end
        tick;
        n_cmp++; if ({a_vvalid, a_vlast, a_mvalid, a_mlast} !== 4'b1111) begin
            n_err++; $display("[TB] FAIL basic_beat1_ctrl: got %b want 1111", {a_vvalid, a_vlast, a_mvalid, a_mlast}); end
        n_cmp++; if (a_vinput !== D2 || a_mrow !== A_ROW1) begin
            n_err++; $display("[TB] FAIL basic_beat1_data: got %h %h want %h %h", a_vinput, a_mrow, D2, A_ROW1); end
        tick;
        n_cmp++; if (a_vvalid !== 1'b0 || a_vlast !== 1'b0 || a_vinput !== D2 || a_busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL basic_wait: got v%b l%b d%h b%b want v0 l0 d%h b1", a_vvalid, a_vlast, a_vinput, a_busy, D2); end
        repeat (9) tick;
        a_beta = 1'b1;
        tick;
        a_beta = 1'b0;
        n_cmp++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL basic_done: got done %b busy %b err %b want 1 0 0", a_done, a_busy, a_err); end
        tick;
        n_cmp++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL basic_after: got done %b busy %b want 0 0", a_done, a_busy); end
    endtask

    task automatic test_beta_in_issue;
        a_start = 1'b1; a_beta = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        n_cmp++; if (a_vvalid !== 1'b1 || a_vlast !== 1'b1 || a_done !== 1'b0) begin
            n_err++; $display("[TB] FAIL beta_issue_beat1: got v%b l%b done%b want 1 1 0", a_vvalid, a_vlast, a_done); end
        tick;
        a_beta = 1'b0;
        n_cmp++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL beta_issue_ignored: got done %b busy %b want 0 1", a_done, a_busy); end
        tick;
        n_cmp++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL beta_issue_still_wait: got done %b busy %b want 0 1", a_done, a_busy); end
        a_beta = 1'b1;
        tick;
        a_beta = 1'b0;
        n_cmp++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL beta_issue_done: got done %b busy %b want 1 0", a_done, a_busy); end
        tick;
    endtask

    task automatic test_illegal_access;
        a_start = 1'b1;
        tick;
        a_start = 1'b1;
        a_v_wr_en = 1'b1; a_v_wr_addr = 2'd0; a_v_wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick;
        a_start = 1'b0; a_v_wr_en = 1'b0;
        n_cmp++; if (a_err !== 1'b1 || a_vvalid !== 1'b1 || a_vlast !== 1'b1 || a_vinput !== D2) begin
            n_err++; $display("[TB] FAIL busy_write_err: got err %b v%b l%b d%h want 1 1 1 %h", a_err, a_vvalid, a_vlast, a_vinput, D2); end
        tick;
        n_cmp++; if (a_err !== 1'b0 || a_vvalid !== 1'b0) begin
            n_err++; $display("[TB] FAIL busy_err_pulse: got err %b valid %b want 0 0", a_err, a_vvalid); end
        a_beta = 1'b1;
        tick;
        a_beta = 1'b0;
        tick;
        n_cmp++; if (a_vvalid !== 1'b0 || a_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL no_second_frame: got valid %b busy %b want 0 0", a_vvalid, a_busy); end
        a_m_wr_en = 1'b1; a_m_wr_addr = 2'd2; a_m_wr_data = {128{1'b1}};
        tick;
        a_m_wr_en = 1'b0;
        n_cmp++; if (a_err !== 1'b1) begin
            n_err++; $display("[TB] FAIL addr_oob_err: got %b want 1", a_err); end
        tick;
        n_cmp++; if (a_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL addr_oob_pulse: got %b want 0", a_err); end
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        n_cmp++; if (a_vinput !== D1 || a_mrow !== A_ROW0) begin
            n_err++; $display("[TB] FAIL buffers_intact0: got %h %h want %h %h", a_vinput, a_mrow, D1, A_ROW0); end
        tick;
        n_cmp++; if (a_vinput !== D2 || a_mrow !== A_ROW1) begin
            n_err++; $display("[TB] FAIL buffers_intact1: got %h %h want %h %h", a_vinput, a_mrow, D2, A_ROW1); end
        tick;
        a_beta = 1'b1;
        tick;
        a_beta = 1'b0;
        tick;
    endtask

    task automatic test_gap_frame;
        int beats;
        int lasts;
        beats = 0; lasts = 0;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        for (int c = 0; c < 53; c++) begin
            if (c > 0) tick;
            if (b_vvalid) beats++;
            if (b_vlast) lasts++;
            n_cmp++; if (b_vvalid !== (c % 4 == 0) || b_mvalid !== (c % 4 == 0) ||
                         b_vlast !== (c == 52) || b_mlast !== (c == 52) ||
                         b_vinput !== exp_v(c / 4) || b_mrow !== exp_m(c / 4)) begin
                n_err++; $display("[TB] FAIL gap_cycle %0d: got v%b l%b d%h m%h want v%b l%b d%h m%h", c,
                                  b_vvalid, b_vlast, b_vinput, b_mrow, (c % 4 == 0), (c == 52), exp_v(c / 4), exp_m(c / 4)); end
        end
        n_cmp++; if (beats != 14 || lasts != 1) begin
            n_err++; $display("[TB] FAIL gap_beat_count: got %0d beats %0d lasts want 14 1", beats, lasts); end
    endtask

    task automatic test_timeout;
        tick;
        n_cmp++; if (b_vvalid !== 1'b0 || b_busy !== 1'b1 || b_vinput !== exp_v(13)) begin
            n_err++; $display("[TB] FAIL timeout_enter: got v%b busy%b d%h want 0 1 %h", b_vvalid, b_busy, b_vinput, exp_v(13)); end
        for (int i = 1; i < 8; i++) begin
            tick;
            n_cmp++; if (b_err !== 1'b0 || b_busy !== 1'b1) begin
                n_err++; $display("[TB] FAIL timeout_early %0d: got err %b busy %b want 0 1", i, b_err, b_busy); end
        end
        tick;
        n_cmp++; if (b_err !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_err: got err %b busy %b done %b want 1 0 0", b_err, b_busy, b_done); end
        tick;
        n_cmp++; if (b_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_pulse: got %b want 0", b_err); end
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n_cmp++; if (b_vvalid !== 1'b1 || b_busy !== 1'b1 || b_vinput !== exp_v(0)) begin
            n_err++; $display("[TB] FAIL timeout_restart: got v%b busy%b d%h want 1 1 %h", b_vvalid, b_busy, b_vinput, exp_v(0)); end
    endtask

    task automatic test_reset_mid_frame;
        repeat (20) tick;
        n_cmp++; if (b_vvalid !== 1'b1 || b_vinput !== exp_v(5)) begin
            n_err++; $display("[TB] FAIL mid_beat5: got v%b d%h want 1 %h", b_vvalid, b_vinput, exp_v(5)); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if ({b_vvalid, b_vlast, b_mvalid, b_mlast, b_busy, b_done, b_err} !== 7'b0 ||
                     b_vinput !== 64'b0 || b_mrow !== 128'b0) begin
            n_err++; $display("[TB] FAIL mid_reset_outputs: got ctrl %b d%h m%h want all 0",
                              {b_vvalid, b_vlast, b_mvalid, b_mlast, b_busy, b_done, b_err}, b_vinput, b_mrow); end
        tick;
        n_cmp++; if (b_vvalid !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL mid_reset_idle: got v%b busy%b done%b err%b want 0", b_vvalid, b_busy, b_done, b_err); end
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n_cmp++; if (b_vinput !== exp_v(0) || b_mrow !== exp_m(0) || b_vvalid !== 1'b1) begin
            n_err++; $display("[TB] FAIL replay_beat0: got %h %h want %h %h", b_vinput, b_mrow, exp_v(0), exp_m(0)); end
        repeat (4) tick;
        n_cmp++; if (b_vinput !== exp_v(1) || b_mrow !== exp_m(1) || b_vvalid !== 1'b1) begin
            n_err++; $display("[TB] FAIL replay_beat1: got %h %h want %h %h", b_vinput, b_mrow, exp_v(1), exp_m(1)); end
        repeat (48) tick;
        n_cmp++; if (b_vlast !== 1'b1 || b_vinput !== exp_v(13) || b_mrow !== exp_m(13)) begin
            n_err++; $display("[TB] FAIL replay_last: got l%b %h %h want 1 %h %h", b_vlast, b_vinput, b_mrow, exp_v(13), exp_m(13)); end
    endtask

    task automatic test_beta_at_timeout;
        tick;
        repeat (7) tick;
        b_beta = 1'b1;
        tick;
        b_beta = 1'b0;
        n_cmp++; if (b_done !== 1'b1 || b_err !== 1'b0 || b_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL beta_at_timeout: got done %b err %b busy %b want 1 0 0", b_done, b_err, b_busy); end
        tick;
        n_cmp++; if (b_done !== 1'b0 || b_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL beta_at_timeout_after: got done %b err %b want 0 0", b_done, b_err); end
    endtask

    initial begin
        test_reset;
        load_buffers;
        test_basic;
        test_beta_in_issue;
        test_illegal_access;
        test_gap_frame;
        test_timeout;
        test_reset_mid_frame;
        test_beta_at_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
